// File: rtl/calc_pkg.sv
// Shared calculator number format.
// num_t: BCD significand, sign, decimal exponent, error.
package calc_pkg;

  localparam int NumDigits = 8;
  localparam int ExpWidth  = $clog2(NumDigits) + 1;

  typedef struct packed {
    logic                       error;
    logic                       sign;
    logic [ExpWidth-1:0]        exponent;
    logic [NumDigits-1:0][3:0]  digits;
  } num_t;

endpackage

// File: rtl/bin2num_converter_if.sv
// Operand/result handshake bundle for bin2num_converter.
// master drives operands and result-ready; slave is the converter.
interface bin2num_converter_if
  import calc_pkg::*;
#(
  parameter int BinWidth = $clog2(10 ** (calc_pkg::NumDigits + 1)) + 1,
  parameter int ExpWidth = calc_pkg::ExpWidth
);

  logic                in_valid_i;
  logic                in_ready_o;
  logic [BinWidth-1:0] in_significand_i;
  logic [ExpWidth-1:0] in_exponent_i;
  logic                in_error_i;
  logic                out_valid_o;
  logic                out_ready_i;
  num_t                out_num_o;
  logic                busy_o;

  modport master (
    output in_valid_i, in_significand_i, in_exponent_i,
    output in_error_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_num_o, busy_o
  );

  modport slave (
    input  in_valid_i, in_significand_i, in_exponent_i,
    input  in_error_i, out_ready_i,
    output in_ready_o, out_valid_o, out_num_o, busy_o
  );

endinterface

// File: rtl/bin2num_converter.sv
// Sequential signed binary -> num_t converter (double-dabble + normalize).
// Optional BIN2NUM_ROUND_EN: round half away from zero instead of truncate.
module bin2num_converter
  import calc_pkg::*;
#(
  parameter int NumDigits   = calc_pkg::NumDigits,
  parameter int ExtraDigits = 1,
  parameter int BinWidth    = $clog2(10 ** (NumDigits + ExtraDigits)) + 1,
  parameter int MaxExponent = 7,
  parameter int ExpWidth    = $clog2(NumDigits) + 1
) (
  input logic               clk_i,
  input logic               rst_i,
  bin2num_converter_if.slave bus
);

  localparam int TotDigits = NumDigits + ExtraDigits;
  localparam int BcdW      = TotDigits * 4;
  localparam int CntW      = $clog2(BinWidth + 1);

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    SHIFT_R,
`ifdef BIN2NUM_ROUND_EN
    ROUND,
`endif
    SHIFT_L,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BinWidth-1:0] bin_q, bin_d;
  logic [BcdW-1:0]     bcd_q, bcd_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ExpWidth-1:0] exp_q, exp_d;
  logic                sign_q, sign_d;
  logic                err_q, err_d;
`ifdef BIN2NUM_ROUND_EN
  logic [3:0]          last_q, last_d;
`endif

  function automatic logic [BcdW-1:0] add3(input logic [BcdW-1:0] b);
    logic [BcdW-1:0] r;
    r = b;
    for (int i = 0; i < TotDigits; i++)
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return r;
  endfunction

`ifdef BIN2NUM_ROUND_EN
  function automatic logic [BcdW-1:0] bcd_inc(input logic [BcdW-1:0] b);
    logic [BcdW-1:0] r;
    logic            c;
    r = b;
    c = 1'b1;
    for (int i = 0; i < TotDigits; i++) begin
      r[i*4 +: 4] = r[i*4 +: 4] + {3'b000, c};
      if (r[i*4 +: 4] == 4'd10) begin
        r[i*4 +: 4] = 4'd0;
      end else begin
        c = 1'b0;
      end
    end
    return r;
  endfunction
`endif

  function automatic logic need_l(
    input logic [BcdW-1:0]     b,
    input logic [ExpWidth-1:0] e,
    input logic                er
  );
    return !er && (e != '0) && (b[NumDigits*4-1 -: 4] == 4'd0);
  endfunction

  // Which phase follows once the digits are known; zero-length phases are skipped.
  function automatic state_t next_phase(
    input logic [BcdW-1:0]     b,
    input logic [ExpWidth-1:0] e,
    input logic                er
`ifdef BIN2NUM_ROUND_EN
    , input logic [3:0]        l
`endif
  );
    if (|b[BcdW-1:NumDigits*4]) return SHIFT_R;
`ifdef BIN2NUM_ROUND_EN
    if (l >= 4'd5) return ROUND;
`endif
    if (need_l(b, e, er)) return SHIFT_L;
    return DONE;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BIN2NUM_ROUND_EN
      last_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
`ifdef BIN2NUM_ROUND_EN
      last_q  <= last_d;
`endif
    end
  end

  // Next-state and datapath update for each phase.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    err_d   = err_q;
`ifdef BIN2NUM_ROUND_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          sign_d  = bus.in_significand_i[BinWidth-1];
          bin_d   = sign_d ? (~bus.in_significand_i + 1'b1)
                           : bus.in_significand_i;
          bcd_d   = '0;
          cnt_d   = '0;
          exp_d   = bus.in_exponent_i;
          err_d   = bus.in_error_i;
`ifdef BIN2NUM_ROUND_EN
          last_d  = '0;
`endif
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        {bcd_d, bin_d} = {add3(bcd_q), bin_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(BinWidth - 1))
          state_d = next_phase(bcd_d, exp_d, err_d
`ifdef BIN2NUM_ROUND_EN
                               , last_d
`endif
                               );
      end
      SHIFT_R: begin
        bcd_d = bcd_q >> 4;
`ifdef BIN2NUM_ROUND_EN
        last_d = bcd_q[3:0];
`endif
        if (exp_q == ExpWidth'(MaxExponent)) err_d = 1'b1;
        else exp_d = exp_q + 1'b1;
        state_d = next_phase(bcd_d, exp_d, err_d
`ifdef BIN2NUM_ROUND_EN
                             , last_d
`endif
                             );
      end
`ifdef BIN2NUM_ROUND_EN
      ROUND: begin
        bcd_d   = bcd_inc(bcd_q);
        last_d  = '0;
        state_d = next_phase(bcd_d, exp_q, err_q, 4'd0);
      end
`endif
      SHIFT_L: begin
        bcd_d   = bcd_q << 4;
        exp_d   = exp_q - 1'b1;
        state_d = need_l(bcd_d, exp_d, err_q) ? SHIFT_L : DONE;
      end
      DONE: begin
        if (bus.out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result fields are presented only while DONE; -0 folds to +0.
  always_comb begin
    bus.out_num_o = '0;
    if (state_q == DONE) begin
      bus.out_num_o.digits   = bcd_q[NumDigits*4-1:0];
      bus.out_num_o.sign     = sign_q && (|bcd_q[NumDigits*4-1:0]);
      bus.out_num_o.error    = err_q;
      bus.out_num_o.exponent = err_q ? '0 : exp_q;
    end
  end

  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.out_valid_o = (state_q == DONE);
  assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_bin2num_converter.sv
// Scoreboard bench for bin2num_converter.
// Arithmetic reference model; monitor checks value and latency.
module tb_bin2num_converter;
  import calc_pkg::*;

  localparam int BW   = 31;
  localparam int ExpW = calc_pkg::ExpWidth;

  typedef struct {
    num_t num;
    int   lat;
    int   acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   stall = 1'b0;
  bit   have  = 1'b0;
  exp_t cur;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2num_converter_if #(.BinWidth(BW), .ExpWidth(ExpW)) bus ();

  bin2num_converter #(.BinWidth(BW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic void model(input longint sig, input int e,
                                input bit ierr, output num_t n,
                                output int lat);
    longint mag;
    longint t;
    int     ex;
    bit     er;
`ifdef BIN2NUM_ROUND_EN
    int     last;
    last = 0;
`endif
    mag = (sig < 0) ? -sig : sig;
    ex  = e;
    er  = ierr;
    lat = 1 + BW;
    while (mag >= 100000000) begin
`ifdef BIN2NUM_ROUND_EN
      last = int'(mag % 10);
`endif
      mag = mag / 10;
      if (ex == 7) er = 1'b1;
      else ex++;
      lat++;
    end
`ifdef BIN2NUM_ROUND_EN
    if (last >= 5) begin
      mag++;
      lat++;
      while (mag >= 100000000) begin
        mag = mag / 10;
        if (ex == 7) er = 1'b1;
        else ex++;
        lat++;
      end
    end
`endif
    if (!er)
      while (ex != 0 && mag < 10000000) begin
        mag = mag * 10;
        ex--;
        lat++;
      end
    n = '0;
    t = mag;
    for (int i = 0; i < 8; i++) begin
      n.digits[i] = 4'(t % 10);
      t = t / 10;
    end
    n.sign     = (sig < 0) && (mag != 0);
    n.error    = er;
    n.exponent = er ? '0 : ExpW'(ex);
  endfunction

  // Monitor: pop expectation on first valid cycle, check every valid cycle.
  always @(negedge clk) begin
    if (rst) begin
      have = 1'b0;
      bus.out_ready_i = 1'b0;
    end else if (bus.out_valid_o) begin
      if (!have) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got %0h want none", bus.out_num_o);
        end else begin
          cur  = sbq.pop_front();
          have = 1'b1;
          chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
        end
      end
      if (have) begin
        chk("out_num", 64'(bus.out_num_o), 64'(cur.num));
        chk("in_ready_in_done", 64'(bus.in_ready_o), 64'd0);
        chk("busy_in_done", 64'(bus.busy_o), 64'd1);
      end
      bus.out_ready_i = !stall && ($urandom_range(2, 0) != 0);
      if (bus.out_ready_i) have = 1'b0;
    end else begin
      bus.out_ready_i = 1'($urandom_range(1, 0));
    end
  end

  task automatic send(input longint sig, input int e, input bit er);
    num_t n;
    int   lat;
    int   w;
    model(sig, e, er, n, lat);
    w = 0;
    @(negedge clk);
    bus.in_valid_i       = 1'b1;
    bus.in_significand_i = BW'(sig);
    bus.in_exponent_i    = ExpW'(e);
    bus.in_error_i       = er;
    while (!bus.in_ready_o && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got busy want ready");
    end else begin
      sbq.push_back('{n, lat, cyc});
    end
    @(posedge clk);
    #1;
    bus.in_valid_i       = 1'b0;
    bus.in_significand_i = BW'($urandom);
    bus.in_exponent_i    = ExpW'($urandom);
    bus.in_error_i       = 1'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sbq.size() != 0 || have) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_in_ready"}, 64'(bus.in_ready_o), 64'd1);
    chk({nm, "_out_valid"}, 64'(bus.out_valid_o), 64'd0);
    chk({nm, "_busy"}, 64'(bus.busy_o), 64'd0);
    chk({nm, "_out_num"}, 64'(bus.out_num_o), 64'd0);
  endtask

  initial begin
    longint p;
    longint s;
    int     w;
    bus.in_valid_i       = 1'b0;
    bus.in_significand_i = '0;
    bus.in_exponent_i    = '0;
    bus.in_error_i       = 1'b0;
    bus.out_ready_i      = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;

    send(12345, 0, 0);
    send(-123456789, 0, 0);
    send(42, 3, 0);
    send(999999999, 7, 0);
    send(5, 0, 1);
    send(0, 5, 0);
    send(-0, 0, 0);
    send(99999999, 0, 0);
    send(100000000, 7, 0);
    send(-999999999, 6, 0);
    send(-1, 7, 0);
    send(123456785, 2, 0);
    drain();

    stall = 1'b1;
    send(777, 1, 0);
    w = 0;
    while (!bus.out_valid_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (5) begin
      chk("valid_hold", 64'(bus.out_valid_o), 64'd1);
      @(negedge clk);
    end
    stall = 1'b0;
    drain();

    send(31415, 2, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sbq.delete();
    @(negedge clk);
    chk_idle("mid_reset");
    rst = 1'b0;

    for (int k = 0; k < 50; k++) begin
      p = 1;
      for (int j = $urandom_range(9, 0); j > 0; j--) p = p * 10;
      s = longint'($urandom) % p;
      if ($urandom_range(1, 0) != 0) s = -s;
      send(s, $urandom_range(7, 0), ($urandom_range(9, 0) == 0));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
